// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the output-buffer FIFO.
// Default word/pointer widths and a depth helper.
package fifo_pkg;

    localparam int FIFO_DW = 8;
    localparam int FIFO_AW = 7;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    localparam int FIFO_DEPTH = fifo_depth(FIFO_AW);

endpackage

// File: rtl/fifo_buffer_if.sv
// fifo_buffer_if: writer/reader bundle of the output-buffer FIFO.
// master drives clear/w_en/data_in/r_en; slave drives data and status.
interface fifo_buffer_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DW,
    parameter int ADDR_WIDTH = FIFO_AW
);
    logic                  clear;
    logic                  w_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  r_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  r_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, w_en, data_in, r_en,
        input  data_out, r_valid, full, empty,
        input  almost_full, almost_empty, count,
        input  overflow, underflow
    );

    modport slave (
        input  clear, w_en, data_in, r_en,
        output data_out, r_valid, full, empty,
        output almost_full, almost_empty, count,
        output overflow, underflow
    );

endinterface

// File: rtl/fifo_mem.sv
// fifo_mem: dual-port storage, clocked write, combinational read.
// Ports: clk, i_w_en/i_waddr/i_wdata (write), i_raddr -> o_rdata.
module fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                  clk,
    input  logic                  i_w_en,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (i_w_en) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_buffer.sv
// fifo_buffer: single-clock FIFO with count, flags and sticky errors.
// Ports: clk, n_rst (async low), bus (fifo_buffer_if.slave).
module fifo_buffer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DW,
    parameter int ADDR_WIDTH = FIFO_AW,
    parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic         clk,
    input  logic         n_rst,
    fifo_buffer_if.slave bus
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(fifo_depth(ADDR_WIDTH));
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] r_wptr;
    logic [ADDR_WIDTH-1:0] r_rptr;
    logic [CW-1:0]         r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_ovf;
    logic                  r_unf;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_mem_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);

    // A full FIFO still takes a write when a read frees a slot
    // on the same edge; an empty one never honours a read.
    assign w_rd_ok  = bus.r_en && !w_empty;
    assign w_wr_ok  = bus.w_en && (!w_full || w_rd_ok);
    assign w_mem_we = w_wr_ok && !bus.clear;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_w_en  (w_mem_we),
        .i_waddr (r_wptr),
        .i_wdata (bus.data_in),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
        end else if (bus.clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_valid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wptr <= r_wptr + ADDR_WIDTH'(1);
            end
            if (w_rd_ok) begin
                r_rptr     <= r_rptr + ADDR_WIDTH'(1);
                r_data_out <= w_rdata;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - CW'(1);
            end
            if (bus.w_en && !w_wr_ok) begin
                r_ovf <= 1'b1;
            end
            if (bus.r_en && !w_rd_ok) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.r_valid      = r_valid;
    assign bus.count        = r_count;
    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= C_AF);
    assign bus.almost_empty = (r_count <= C_AE);
    assign bus.overflow     = r_ovf;
    assign bus.underflow    = r_unf;

endmodule
